// File: rtl/mixcol_seq.sv
// Iterative AES-128 MixColumns engine: a shared column datapath steps through the
// four state columns, COLS_PER_CYCLE per clock, with a pass-through for the final round.

module gf_mul2 (
    input  logic [7:0] i_a,
    output logic [7:0] o_y
);
    assign o_y = {i_a[6:0], 1'b0} ^ (i_a[7] ? 8'h1b : 8'h00);
endmodule

module gf_mul3 (
    input  logic [7:0] i_a,
    output logic [7:0] o_y
);
    logic [7:0] w_x2;

    gf_mul2 u_x2 (.i_a(i_a), .o_y(w_x2));

    assign o_y = w_x2 ^ i_a;
endmodule

module mixcol_lane (
    input  logic [31:0] i_col,
    output logic [31:0] o_col
);
    logic [7:0] w_a  [4];
    logic [7:0] w_m2 [4];
    logic [7:0] w_m3 [4];

    for (genvar k = 0; k < 4; k++) begin : g_byte
        assign w_a[k] = i_col[31-8*k -: 8];
        gf_mul2 u_m2 (.i_a(w_a[k]), .o_y(w_m2[k]));
        gf_mul3 u_m3 (.i_a(w_a[k]), .o_y(w_m3[k]));
    end

    assign o_col[31:24] = w_m2[0] ^ w_m3[1] ^ w_a[2]  ^ w_a[3];
    assign o_col[23:16] = w_a[0]  ^ w_m2[1] ^ w_m3[2] ^ w_a[3];
    assign o_col[15:8]  = w_a[0]  ^ w_a[1]  ^ w_m2[2] ^ w_m3[3];
    assign o_col[7:0]   = w_m3[0] ^ w_a[1]  ^ w_a[2]  ^ w_m2[3];
endmodule

module mixcol_seq #(
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         in_bypass,
    input  logic [127:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy
);
    if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_badParam
        $error("mixcol_seq: COLS_PER_CYCLE must be 1, 2 or 4");
    end

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [1:0] STEP     = 2'(COLS_PER_CYCLE);
    localparam logic [1:0] LAST_CNT = 2'(4 - COLS_PER_CYCLE);

    state_t         r_state;
    state_t         w_nextState;
    logic [1:0]     r_cnt;
    logic [127:0]   r_work;
    logic [127:0]   w_workNext;
    logic [31:0]    w_cols     [4];
    logic [31:0]    w_nextCols [4];
    logic [31:0]    w_laneIn   [COLS_PER_CYCLE];
    logic [31:0]    w_laneOut  [COLS_PER_CYCLE];
    logic [1:0]     w_laneIdx  [COLS_PER_CYCLE];

    for (genvar c = 0; c < 4; c++) begin : g_cols
        assign w_cols[c] = r_work[127-32*c -: 32];
    end

    // Lane l always works on column cnt+l; cnt is a multiple of the lane count, so it never overflows.
    for (genvar l = 0; l < COLS_PER_CYCLE; l++) begin : g_lane
        assign w_laneIdx[l] = r_cnt + 2'(l);
        assign w_laneIn[l]  = w_cols[w_laneIdx[l]];
        mixcol_lane u_lane (.i_col(w_laneIn[l]), .o_col(w_laneOut[l]));
    end

    always_comb begin
        w_nextCols = w_cols;
        w_workNext = '0;
        for (int l = 0; l < COLS_PER_CYCLE; l++) begin
            w_nextCols[w_laneIdx[l]] = w_laneOut[l];
        end
        for (int c = 0; c < 4; c++) begin
            w_workNext[127-32*c -: 32] = w_nextCols[c];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE: begin
                if (in_valid) begin
                    w_nextState = in_bypass ? DONE : RUN;
                end
            end
            RUN: begin
                if (r_cnt == LAST_CNT) begin
                    w_nextState = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    w_nextState = IDLE;
                end
            end
            default: w_nextState = IDLE;
        endcase
    end

    // The work register doubles as the output register, so the result holds through DONE and after.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_work <= '0;
            r_cnt  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_work <= in_data;
                        r_cnt  <= '0;
                    end
                end
                RUN: begin
                    r_work <= w_workNext;
                    r_cnt  <= r_cnt + STEP;
                end
                default: begin
                end
            endcase
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign busy      = (r_state != IDLE);
    assign out_data  = r_work;
endmodule

// File: tb/tb_mixcol_seq.sv
// Testbench for mixcol_seq: three instances (1, 2 and 4 columns per cycle) checked
// against a matrix-multiply MixColumns model, plus backpressure, reset and throughput scenarios.

module tb_mixcol_seq;
    logic         clk = 1'b0;
    logic         rst;
    logic [127:0] inData;
    logic         inBypass;
    logic         inValid  [3];
    logic         outReady [3];
    logic         inReady  [3];
    logic         outValid [3];
    logic         busy     [3];
    logic [127:0] outData  [3];

    int checks   = 0;
    int failures = 0;

    localparam logic [127:0] VEC1_IN  = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
    localparam logic [127:0] VEC1_OUT = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
    localparam logic [127:0] VEC2_IN  = 128'hd4d4d4d5_2d26314c_00000000_ffffffff;
    localparam logic [127:0] VEC2_OUT = 128'hd5d5d7d6_4d7ebdf8_00000000_ffffffff;
    localparam logic [127:0] VEC3_IN  = 128'h00112233_44556677_8899aabb_ccddeeff;

    always #5 clk = ~clk;

    mixcol_seq #(.COLS_PER_CYCLE(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(inValid[0]), .in_ready(inReady[0]),
        .in_bypass(inBypass), .in_data(inData), .out_valid(outValid[0]),
        .out_ready(outReady[0]), .out_data(outData[0]), .busy(busy[0])
    );
    mixcol_seq #(.COLS_PER_CYCLE(2)) dut2 (
        .clk(clk), .rst(rst), .in_valid(inValid[1]), .in_ready(inReady[1]),
        .in_bypass(inBypass), .in_data(inData), .out_valid(outValid[1]),
        .out_ready(outReady[1]), .out_data(outData[1]), .busy(busy[1])
    );
    mixcol_seq #(.COLS_PER_CYCLE(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(inValid[2]), .in_ready(inReady[2]),
        .in_bypass(inBypass), .in_data(inData), .out_valid(outValid[2]),
        .out_ready(outReady[2]), .out_data(outData[2]), .busy(busy[2])
    );

    function automatic int cpcOf(input int idx);
        return (idx == 0) ? 1 : (idx == 1) ? 2 : 4;
    endfunction

    // Generic GF(2^8) product by shift-and-add, reduced by x^8+x^4+x^3+x+1.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
        end
        return p;
    endfunction

    function automatic logic [127:0] refMix(input logic [127:0] s, input bit byp);
        logic [7:0]   a [4];
        logic [7:0]   acc;
        logic [127:0] o;
        int           coef [4];
        coef = '{2, 3, 1, 1};
        if (byp) return s;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int k = 0; k < 4; k++) a[k] = s[127-8*(4*c+k) -: 8];
            for (int r = 0; r < 4; r++) begin
                acc = 8'h00;
                for (int k = 0; k < 4; k++) acc = acc ^ gmul(a[k], 8'(coef[(k - r + 4) % 4]));
                o[127-8*(4*c+r) -: 8] = acc;
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] randState();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Offers one block to instance idx; lat = clock edges after the accept edge until out_valid is seen.
    task automatic runBlock(input int idx, input logic [127:0] d, input bit byp,
                            output int lat, output logic [127:0] res, output bit ok);
        int n;
        ok  = 1'b1;
        lat = 0;
        n   = 0;
        while (!inReady[idx] && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (!inReady[idx]) begin
            ok  = 1'b0;
            res = outData[idx];
            return;
        end
        inData       = d;
        inBypass     = byp;
        inValid[idx] = 1'b1;
        @(posedge clk); #1;
        inValid[idx] = 1'b0;
        while (!outValid[idx] && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!outValid[idx]) ok = 1'b0;
        res = outData[idx];
    endtask

    task automatic test_reset();
        rst      = 1'b1;
        inData   = '0;
        inBypass = 1'b0;
        for (int i = 0; i < 3; i++) begin
            inValid[i]  = 1'b0;
            outReady[i] = 1'b1;
        end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (inReady[i] !== 1'b1) begin
                failures++;
                $display("[TB] FAIL reset_in_ready[%0d] got=%b want=1", i, inReady[i]);
            end
            checks++;
            if (busy[i] !== 1'b0) begin
                failures++;
                $display("[TB] FAIL reset_busy[%0d] got=%b want=0", i, busy[i]);
            end
            checks++;
            if (outValid[i] !== 1'b0) begin
                failures++;
                $display("[TB] FAIL reset_out_valid[%0d] got=%b want=0", i, outValid[i]);
            end
            checks++;
            if (outData[i] !== 128'h0) begin
                failures++;
                $display("[TB] FAIL reset_out_data[%0d] got=%h want=0", i, outData[i]);
            end
        end
    endtask

    task automatic test_vectors();
        int           lat;
        logic [127:0] res;
        bit           ok;
        runBlock(0, VEC1_IN, 1'b0, lat, res, ok);
        checks++;
        if (!ok || res !== VEC1_OUT) begin
            failures++;
            $display("[TB] FAIL vec1_data got=%h want=%h ok=%0d", res, VEC1_OUT, ok);
        end
        checks++;
        if (lat !== 4) begin
            failures++;
            $display("[TB] FAIL vec1_latency got=%0d want=4", lat);
        end
        for (int i = 0; i < 3; i++) begin
            runBlock(i, VEC2_IN, 1'b0, lat, res, ok);
            checks++;
            if (!ok || res !== VEC2_OUT || res !== refMix(VEC2_IN, 1'b0)) begin
                failures++;
                $display("[TB] FAIL vec2_data[cpc=%0d] got=%h want=%h ok=%0d", cpcOf(i), res, VEC2_OUT, ok);
            end
            checks++;
            if (lat !== 4 / cpcOf(i)) begin
                failures++;
                $display("[TB] FAIL vec2_latency[cpc=%0d] got=%0d want=%0d", cpcOf(i), lat, 4 / cpcOf(i));
            end
        end
    endtask

    task automatic test_bypass();
        int           lat;
        logic [127:0] res;
        bit           ok;
        for (int i = 0; i < 3; i++) begin
            runBlock(i, VEC3_IN, 1'b1, lat, res, ok);
            checks++;
            if (!ok || res !== VEC3_IN) begin
                failures++;
                $display("[TB] FAIL bypass_data[cpc=%0d] got=%h want=%h ok=%0d", cpcOf(i), res, VEC3_IN, ok);
            end
            checks++;
            if (lat !== 0) begin
                failures++;
                $display("[TB] FAIL bypass_latency[cpc=%0d] got=%0d edges want=0", cpcOf(i), lat);
            end
        end
        inBypass = 1'b0;
    endtask

    task automatic test_backpressure();
        int           lat;
        logic [127:0] res;
        logic [127:0] d;
        logic [127:0] exp;
        bit           ok;
        d   = randState();
        exp = refMix(d, 1'b0);
        outReady[0] = 1'b0;
        runBlock(0, d, 1'b0, lat, res, ok);
        checks++;
        if (!ok || res !== exp) begin
            failures++;
            $display("[TB] FAIL bp_first_data got=%h want=%h ok=%0d", res, exp, ok);
        end
        for (int n = 0; n < 10; n++) begin
            @(posedge clk); #1;
            checks++;
            if (outValid[0] !== 1'b1 || inReady[0] !== 1'b0 || outData[0] !== exp) begin
                failures++;
                $display("[TB] FAIL bp_hold[%0d] got valid=%b ready=%b data=%h want valid=1 ready=0 data=%h",
                         n, outValid[0], inReady[0], outData[0], exp);
            end
        end
        outReady[0] = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (inReady[0] !== 1'b1 || outValid[0] !== 1'b0 || busy[0] !== 1'b0) begin
            failures++;
            $display("[TB] FAIL bp_release got ready=%b valid=%b busy=%b want ready=1 valid=0 busy=0",
                     inReady[0], outValid[0], busy[0]);
        end
        checks++;
        if (outData[0] !== exp) begin
            failures++;
            $display("[TB] FAIL bp_data_kept got=%h want=%h", outData[0], exp);
        end
    endtask

    task automatic test_reset_mid_run();
        int           lat;
        logic [127:0] res;
        bit           ok;
        inData     = VEC2_IN;
        inBypass   = 1'b0;
        inValid[0] = 1'b1;
        @(posedge clk); #1;
        inValid[0] = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++;
        if (outValid[0] !== 1'b0 || inReady[0] !== 1'b1 || outData[0] !== 128'h0) begin
            failures++;
            $display("[TB] FAIL midrun_reset got valid=%b ready=%b data=%h want valid=0 ready=1 data=0",
                     outValid[0], inReady[0], outData[0]);
        end
        runBlock(0, VEC1_IN, 1'b0, lat, res, ok);
        checks++;
        if (!ok || res !== VEC1_OUT || lat !== 4) begin
            failures++;
            $display("[TB] FAIL midrun_followup got=%h lat=%0d want=%h lat=4 ok=%0d", res, lat, VEC1_OUT, ok);
        end
    endtask

    task automatic test_random();
        int           lat;
        logic [127:0] res;
        logic [127:0] d;
        bit           ok;
        bit           byp;
        for (int i = 0; i < 3; i++) begin
            for (int n = 0; n < 8; n++) begin
                d   = randState();
                byp = ($urandom_range(0, 3) == 0);
                runBlock(i, d, byp, lat, res, ok);
                checks++;
                if (!ok || res !== refMix(d, byp)) begin
                    failures++;
                    $display("[TB] FAIL random_data[cpc=%0d,%0d] got=%h want=%h ok=%0d",
                             cpcOf(i), n, res, refMix(d, byp), ok);
                end
                checks++;
                if (lat !== (byp ? 0 : 4 / cpcOf(i))) begin
                    failures++;
                    $display("[TB] FAIL random_latency[cpc=%0d,%0d] got=%0d want=%0d",
                             cpcOf(i), n, lat, byp ? 0 : 4 / cpcOf(i));
                end
            end
        end
        inBypass = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [127:0] expQ [$];
        int           acceptCyc [$];
        logic [127:0] exp;
        int           accepts;
        int           got;
        bit           willAccept;
        accepts  = 0;
        got      = 0;
        @(posedge clk); #1;
        outReady[0] = 1'b1;
        inBypass    = 1'b0;
        inData      = randState();
        inValid[0]  = 1'b1;
        for (int cyc = 0; cyc < 80 && got < 5; cyc++) begin
            willAccept = inValid[0] && inReady[0];
            @(posedge clk); #1;
            if (willAccept) begin
                acceptCyc.push_back(cyc);
                expQ.push_back(refMix(inData, 1'b0));
                inData = randState();
                accepts++;
                if (accepts == 5) inValid[0] = 1'b0;
            end
            if (outValid[0]) begin
                got++;
                exp = (expQ.size() > 0) ? expQ.pop_front() : 128'hx;
                checks++;
                if (outData[0] !== exp) begin
                    failures++;
                    $display("[TB] FAIL b2b_data[%0d] got=%h want=%h", got, outData[0], exp);
                end
            end
        end
        inValid[0] = 1'b0;
        checks++;
        if (got !== 5) begin
            failures++;
            $display("[TB] FAIL b2b_count got=%0d results want=5", got);
        end
        for (int k = 1; k < acceptCyc.size(); k++) begin
            checks++;
            if (acceptCyc[k] - acceptCyc[k-1] !== 6) begin
                failures++;
                $display("[TB] FAIL b2b_interval[%0d] got=%0d cycles want=6", k, acceptCyc[k] - acceptCyc[k-1]);
            end
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog got=timeout want=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_vectors();
        test_bypass();
        test_backpressure();
        test_reset_mid_run();
        test_random();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
